// File: rtl/i2s_clkws_cfg_seq_if.sv
// Configuration bus between the I2S register file and the clock/WS reconfiguration
// sequencer. Signal suffixes are from the sequencer's point of view.
interface i2s_clkws_cfg_seq_if #(
  parameter int unsigned DRAIN_W = 16
) ();
  // Requested configuration (register file -> sequencer)
  logic               cfg_commit_i;
  logic               cfg_master_en_i;
  logic               cfg_slave_en_i;
  logic               cfg_pdm_en_i;
  logic               cfg_sel_master_num_i;
  logic               cfg_sel_master_ext_i;
  logic               cfg_sel_slave_num_i;
  logic               cfg_sel_slave_ext_i;
  logic [15:0]        cfg_div_0_i;
  logic [15:0]        cfg_div_1_i;
  logic [4:0]         cfg_word_size_0_i;
  logic [4:0]         cfg_word_size_1_i;
  logic [3:0]         cfg_word_num_0_i;
  logic [3:0]         cfg_word_num_1_i;
  logic               cfg_master_dsp_en_i;
  logic               cfg_slave_dsp_en_i;
  logic [DRAIN_W-1:0] cfg_drain_cycles_i;
  logic [DRAIN_W-1:0] cfg_settle_cycles_i;

  // Applied configuration and status (sequencer -> generator / register file)
  logic               master_en_o;
  logic               slave_en_o;
  logic               pdm_en_o;
  logic               sel_master_num_o;
  logic               sel_master_ext_o;
  logic               sel_slave_num_o;
  logic               sel_slave_ext_o;
  logic [15:0]        div_0_o;
  logic [15:0]        div_1_o;
  logic [4:0]         word_size_0_o;
  logic [4:0]         word_size_1_o;
  logic [3:0]         word_num_0_o;
  logic [3:0]         word_num_1_o;
  logic               master_dsp_en_o;
  logic               slave_dsp_en_o;
  logic               busy_o;
  logic               done_o;
  logic               pending_o;

  modport master (
    output cfg_commit_i, cfg_master_en_i, cfg_slave_en_i, cfg_pdm_en_i,
           cfg_sel_master_num_i, cfg_sel_master_ext_i, cfg_sel_slave_num_i,
           cfg_sel_slave_ext_i, cfg_div_0_i, cfg_div_1_i, cfg_word_size_0_i,
           cfg_word_size_1_i, cfg_word_num_0_i, cfg_word_num_1_i,
           cfg_master_dsp_en_i, cfg_slave_dsp_en_i, cfg_drain_cycles_i,
           cfg_settle_cycles_i,
    input  master_en_o, slave_en_o, pdm_en_o, sel_master_num_o, sel_master_ext_o,
           sel_slave_num_o, sel_slave_ext_o, div_0_o, div_1_o, word_size_0_o,
           word_size_1_o, word_num_0_o, word_num_1_o, master_dsp_en_o,
           slave_dsp_en_o, busy_o, done_o, pending_o
  );

  modport slave (
    input  cfg_commit_i, cfg_master_en_i, cfg_slave_en_i, cfg_pdm_en_i,
           cfg_sel_master_num_i, cfg_sel_master_ext_i, cfg_sel_slave_num_i,
           cfg_sel_slave_ext_i, cfg_div_0_i, cfg_div_1_i, cfg_word_size_0_i,
           cfg_word_size_1_i, cfg_word_num_0_i, cfg_word_num_1_i,
           cfg_master_dsp_en_i, cfg_slave_dsp_en_i, cfg_drain_cycles_i,
           cfg_settle_cycles_i,
    output master_en_o, slave_en_o, pdm_en_o, sel_master_num_o, sel_master_ext_o,
           sel_slave_num_o, sel_slave_ext_o, div_0_o, div_1_o, word_size_0_o,
           word_size_1_o, word_num_0_o, word_num_1_o, master_dsp_en_o,
           slave_dsp_en_o, busy_o, done_o, pending_o
  );
endinterface

// File: rtl/i2s_clkws_cfg_seq.sv
// Glitch-safe reconfiguration sequencer for the I2S clock/WS generator.
// Committed configuration is applied as: drop enables, drain, switch selects and
// dividers, settle, re-assert enables. One extra commit can be queued while busy.
module i2s_clkws_cfg_seq #(
  parameter int unsigned DRAIN_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  i2s_clkws_cfg_seq_if.slave   bus
);

  // Everything except the enables; only ever updated in SWITCH.
  typedef struct packed {
    logic        sel_master_num;
    logic        sel_master_ext;
    logic        sel_slave_num;
    logic        sel_slave_ext;
    logic [15:0] div_0;
    logic [15:0] div_1;
    logic [4:0]  word_size_0;
    logic [4:0]  word_size_1;
    logic [3:0]  word_num_0;
    logic [3:0]  word_num_1;
    logic        master_dsp_en;
    logic        slave_dsp_en;
  } set_t;

  // Full commit snapshot; en is {master, slave, pdm}.
  typedef struct packed {
    logic [2:0]         en;
    set_t               set;
    logic [DRAIN_W-1:0] drain;
    logic [DRAIN_W-1:0] settle;
  } snap_t;

  // Staging keeps no drain count: it is consumed when the counter is loaded.
  typedef struct packed {
    logic [2:0]         en;
    set_t               set;
    logic [DRAIN_W-1:0] settle;
  } stage_t;

  typedef enum logic [2:0] {StIdle, StDrain, StSwitch, StSettle, StEnable} state_e;

  state_e             state_q;
  stage_t             stage_q;
  snap_t              pend_q;
  logic               pend_vld_q;
  logic [DRAIN_W-1:0] cnt_q;
  logic [2:0]         en_q;
  set_t               set_q;
  logic               busy_q;
  logic               done_q;

  snap_t snap;
  snap_t promo;

  // A drain count of zero still holds DRAIN for one cycle.
  function automatic logic [DRAIN_W-1:0] drain_load(input logic [DRAIN_W-1:0] d);
    return (d == '0) ? DRAIN_W'(1) : d;
  endfunction

  // Snapshot of the live request and the source used when chaining out of ENABLE.
  always_comb begin
    snap                    = '0;
    snap.en                 = {bus.cfg_master_en_i, bus.cfg_slave_en_i, bus.cfg_pdm_en_i};
    snap.set.sel_master_num = bus.cfg_sel_master_num_i;
    snap.set.sel_master_ext = bus.cfg_sel_master_ext_i;
    snap.set.sel_slave_num  = bus.cfg_sel_slave_num_i;
    snap.set.sel_slave_ext  = bus.cfg_sel_slave_ext_i;
    snap.set.div_0          = bus.cfg_div_0_i;
    snap.set.div_1          = bus.cfg_div_1_i;
    snap.set.word_size_0    = bus.cfg_word_size_0_i;
    snap.set.word_size_1    = bus.cfg_word_size_1_i;
    snap.set.word_num_0     = bus.cfg_word_num_0_i;
    snap.set.word_num_1     = bus.cfg_word_num_1_i;
    snap.set.master_dsp_en  = bus.cfg_master_dsp_en_i;
    snap.set.slave_dsp_en   = bus.cfg_slave_dsp_en_i;
    snap.drain              = bus.cfg_drain_cycles_i;
    snap.settle             = bus.cfg_settle_cycles_i;
    promo                   = pend_vld_q ? pend_q : snap;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      stage_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      en_q       <= '0;
      set_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Commits outside IDLE land in the one-deep pending slot, last one wins.
      if (bus.cfg_commit_i && (state_q != StIdle)) begin
        pend_q     <= snap;
        pend_vld_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.cfg_commit_i) begin
            stage_q <= '{en: snap.en, set: snap.set, settle: snap.settle};
            en_q    <= '0;
            busy_q  <= 1'b1;
            if (|en_q) begin
              cnt_q   <= drain_load(snap.drain);
              state_q <= StDrain;
            end else begin
              state_q <= StSwitch;
            end
          end
        end
        StDrain: begin
          cnt_q <= cnt_q - DRAIN_W'(1);
          if (cnt_q == DRAIN_W'(1)) state_q <= StSwitch;
        end
        StSwitch: begin
          set_q <= stage_q.set;
          if (stage_q.settle != '0) begin
            cnt_q   <= stage_q.settle;
            state_q <= StSettle;
          end else begin
            en_q    <= stage_q.en;
            done_q  <= 1'b1;
            state_q <= StEnable;
          end
        end
        StSettle: begin
          cnt_q <= cnt_q - DRAIN_W'(1);
          if (cnt_q == DRAIN_W'(1)) begin
            en_q    <= stage_q.en;
            done_q  <= 1'b1;
            state_q <= StEnable;
          end
        end
        StEnable: begin
          // Enables were just raised, so a queued (or same-cycle) commit must drain.
          if (pend_vld_q || bus.cfg_commit_i) begin
            stage_q <= '{en: promo.en, set: promo.set, settle: promo.settle};
            cnt_q   <= drain_load(promo.drain);
            en_q    <= '0;
            state_q <= StDrain;
            // A commit consumed directly here must not also stay queued.
            if (!(pend_vld_q && bus.cfg_commit_i)) pend_vld_q <= 1'b0;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.master_en_o      = en_q[2];
  assign bus.slave_en_o       = en_q[1];
  assign bus.pdm_en_o         = en_q[0];
  assign bus.sel_master_num_o = set_q.sel_master_num;
  assign bus.sel_master_ext_o = set_q.sel_master_ext;
  assign bus.sel_slave_num_o  = set_q.sel_slave_num;
  assign bus.sel_slave_ext_o  = set_q.sel_slave_ext;
  assign bus.div_0_o          = set_q.div_0;
  assign bus.div_1_o          = set_q.div_1;
  assign bus.word_size_0_o    = set_q.word_size_0;
  assign bus.word_size_1_o    = set_q.word_size_1;
  assign bus.word_num_0_o     = set_q.word_num_0;
  assign bus.word_num_1_o     = set_q.word_num_1;
  assign bus.master_dsp_en_o  = set_q.master_dsp_en;
  assign bus.slave_dsp_en_o   = set_q.slave_dsp_en;
  assign bus.busy_o           = busy_q;
  assign bus.done_o           = done_q;
  assign bus.pending_o        = pend_vld_q;

endmodule

// File: tb/tb_i2s_clkws_cfg_seq.sv
// Directed bench for the I2S clock/WS reconfiguration sequencer.
module tb_i2s_clkws_cfg_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;
  logic [63:0] all_out;

  always #5 clk = ~clk;

  i2s_clkws_cfg_seq_if #(.DRAIN_W(16)) bus ();

  i2s_clkws_cfg_seq #(.DRAIN_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always_comb begin
    all_out = {2'b00, bus.master_en_o, bus.slave_en_o, bus.pdm_en_o,
               bus.sel_master_num_o, bus.sel_master_ext_o, bus.sel_slave_num_o,
               bus.sel_slave_ext_o, bus.div_0_o, bus.div_1_o, bus.word_size_0_o,
               bus.word_size_1_o, bus.word_num_0_o, bus.word_num_1_o,
               bus.master_dsp_en_o, bus.slave_dsp_en_o, bus.busy_o, bus.done_o,
               bus.pending_o};
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    bus.cfg_commit_i = 1'b0;
  endtask

  task automatic set_cfg(input logic men, input logic sen, input logic pen,
                         input logic sel_ext, input logic [15:0] div0,
                         input logic [15:0] drain, input logic [15:0] settle);
    bus.cfg_master_en_i      = men;
    bus.cfg_slave_en_i       = sen;
    bus.cfg_pdm_en_i         = pen;
    bus.cfg_sel_master_num_i = 1'b0;
    bus.cfg_sel_master_ext_i = sel_ext;
    bus.cfg_sel_slave_num_i  = 1'b0;
    bus.cfg_sel_slave_ext_i  = 1'b0;
    bus.cfg_div_0_i          = div0;
    bus.cfg_div_1_i          = 16'h0;
    bus.cfg_word_size_0_i    = 5'h0;
    bus.cfg_word_size_1_i    = 5'h0;
    bus.cfg_word_num_0_i     = 4'h0;
    bus.cfg_word_num_1_i     = 4'h0;
    bus.cfg_master_dsp_en_i  = 1'b0;
    bus.cfg_slave_dsp_en_i   = 1'b0;
    bus.cfg_drain_cycles_i   = drain;
    bus.cfg_settle_cycles_i  = settle;
  endtask

  task automatic commit(input logic men, input logic sen, input logic pen,
                        input logic sel_ext, input logic [15:0] div0,
                        input logic [15:0] drain, input logic [15:0] settle);
    set_cfg(men, sen, pen, sel_ext, div0, drain, settle);
    bus.cfg_commit_i = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with random stimulus on every input.
    for (int i = 0; i < 3; i++) begin
      commit(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom));
      bus.cfg_sel_slave_ext_i = 1'($urandom);
      bus.cfg_div_1_i         = 16'($urandom);
      bus.cfg_word_size_0_i   = 5'($urandom);
      bus.cfg_word_num_1_i    = 4'($urandom);
      @(posedge clk);
      #1;
    end
    check("rst_outputs", all_out, 64'h0);
    rst = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    bus.cfg_commit_i = 1'b0;
    step();
    check("rst_idle", all_out, 64'h0);

    // Cold start: enables off, drain skipped, settle=2.
    commit(1'b1, 1'b0, 1'b0, 1'b0, 16'd8, 16'd5, 16'd2);
    for (int c = 1; c <= 5; c++) begin
      step();
      check("cold_div0", 64'(bus.div_0_o), (c >= 2) ? 64'd8 : 64'd0);
      check("cold_men", 64'(bus.master_en_o), 64'(c >= 4));
      check("cold_done", 64'(bus.done_o), 64'(c == 4));
      check("cold_busy", 64'(bus.busy_o), 64'(c <= 4));
    end

    // Live source switch; inputs change after commit and must not leak through.
    commit(1'b1, 1'b0, 1'b0, 1'b1, 16'd8, 16'd10, 16'd3);
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 1) set_cfg(1'b0, 1'b1, 1'b1, 1'b0, 16'hdead, 16'd0, 16'd0);
      check("live_men", 64'(bus.master_en_o), 64'(c >= 15));
      check("live_ext", 64'(bus.sel_master_ext_o), 64'(c >= 12));
      check("live_div0", 64'(bus.div_0_o), 64'd8);
      check("live_done", 64'(bus.done_o), 64'(c == 15));
      check("live_busy", 64'(bus.busy_o), 64'(c <= 15));
    end

    // Queued commits: A, then B and C during A's drain; B must never appear.
    commit(1'b1, 1'b0, 1'b0, 1'b1, 16'h11, 16'd4, 16'd1);
    for (int c = 1; c <= 13; c++) begin
      step();
      check("q_div0", 64'(bus.div_0_o),
            (c < 6) ? 64'd8 : ((c < 11) ? 64'h11 : 64'h33));
      check("q_men", 64'(bus.master_en_o), 64'(c == 7));
      check("q_sen", 64'(bus.slave_en_o), 64'd0);
      check("q_pen", 64'(bus.pdm_en_o), 64'(c >= 12));
      check("q_pend", 64'(bus.pending_o), 64'(c >= 3 && c <= 7));
      check("q_done", 64'(bus.done_o), 64'(c == 7 || c == 12));
      check("q_busy", 64'(bus.busy_o), 64'(c <= 12));
      if (c == 2) commit(1'b0, 1'b1, 1'b0, 1'b1, 16'h22, 16'd2, 16'd0);
      if (c == 3) commit(1'b0, 1'b0, 1'b1, 1'b1, 16'h33, 16'd2, 16'd1);
    end

    // Boundary: drain=0 acts as 1, settle=0 skips SETTLE.
    commit(1'b1, 1'b0, 1'b0, 1'b1, 16'h44, 16'd0, 16'd0);
    for (int c = 1; c <= 4; c++) begin
      step();
      check("bnd_div0", 64'(bus.div_0_o), (c >= 3) ? 64'h44 : 64'h33);
      check("bnd_men", 64'(bus.master_en_o), 64'(c >= 3));
      check("bnd_pen", 64'(bus.pdm_en_o), 64'd0);
      check("bnd_done", 64'(bus.done_o), 64'(c == 3));
      check("bnd_busy", 64'(bus.busy_o), 64'(c <= 3));
    end

    // Reset during SETTLE (drain 2: SWITCH at 3, SETTLE 4..8), then a clean run.
    commit(1'b1, 1'b0, 1'b0, 1'b0, 16'h66, 16'd2, 16'd5);
    for (int c = 1; c <= 8; c++) begin
      step();
      rst = 1'b0;
      if (c <= 5) check("mid_busy", 64'(bus.busy_o), 64'd1);
      if (c >= 6) check("mid_rst_out", all_out, 64'h0);
      if (c == 5) rst = 1'b1;
    end
    commit(1'b1, 1'b0, 1'b0, 1'b0, 16'h55, 16'd3, 16'd1);
    for (int c = 1; c <= 4; c++) begin
      step();
      check("post_div0", 64'(bus.div_0_o), (c >= 2) ? 64'h55 : 64'h0);
      check("post_men", 64'(bus.master_en_o), 64'(c >= 3));
      check("post_done", 64'(bus.done_o), 64'(c == 3));
      check("post_busy", 64'(bus.busy_o), 64'(c <= 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_clkws_cfg_seq.md
# i2s_clkws_cfg_seq

Reconfiguration sequencer for the I2S clock/WS generator. Captures a software-committed configuration snapshot of enables, clock-source selects, dividers, word size/count and DSP settings, then applies it in a glitch-safe order. The order is: drop the active interface enables, drain for a programmable number of cycles, switch selects and dividers, settle, then re-assert enables. Sits between the uDMA I2S register file and the clock/WS generator; all generator configuration inputs are driven from this block's registered outputs.

## Interface
- DRAIN_W, 16: width of drain and settle counters.
- clk_i  in  1  system clock; sole clock of the block.
- rst_i  in  1  reset, synchronous, active-high.
- cfg_commit_i  in  1  single-cycle pulse; snapshot all cfg_*_i this cycle.
- cfg_master_en_i / cfg_slave_en_i / cfg_pdm_en_i  in  1 each  requested enables.
- cfg_sel_master_num_i / cfg_sel_master_ext_i / cfg_sel_slave_num_i / cfg_sel_slave_ext_i  in  1 each  requested clock/WS source selects.
- cfg_div_0_i / cfg_div_1_i  in  16 each  requested divider values.
- cfg_word_size_0_i / cfg_word_size_1_i  in  5 each; cfg_word_num_0_i / cfg_word_num_1_i  in  4 each.
- cfg_master_dsp_en_i / cfg_slave_dsp_en_i  in  1 each.
- cfg_drain_cycles_i  in  DRAIN_W  cycles held in DRAIN; 0 treated as 1.
- cfg_settle_cycles_i  in  DRAIN_W  cycles held in SETTLE; 0 skips SETTLE.
- master_en_o / slave_en_o / pdm_en_o  out  1 each  applied enables.
- sel_*_o, div_0_o, div_1_o, word_size_*_o, word_num_*_o, *_dsp_en_o  out  match the corresponding inputs  applied configuration.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse when new configuration is fully applied.
- pending_o  out  1  a second commit is queued.

## Operation
- States: IDLE, DRAIN, SWITCH, SETTLE, ENABLE.
- IDLE + commit:
  - Snapshot into the staging register.
  - Clear all enable outputs.
  - If any enable output was high: go to DRAIN and load the counter with max(drain,1).
  - Otherwise: go directly to SWITCH.
- DRAIN: decrement each cycle; at counter==1 go to SWITCH.
- SWITCH, one cycle: copy staged selects, dividers, word size/num and DSP enables to the outputs. Enables stay 0. If settle!=0, load the counter and go to SETTLE; else go to ENABLE.
- SETTLE: decrement each cycle; at counter==1 go to ENABLE.
- ENABLE, one cycle: copy staged enables to the outputs, pulse done_o, go to IDLE.
- Drain and settle counts are sampled at commit, not live.
- Commit while busy:
  - Snapshot into a one-deep pending register and set pending_o.
  - A later commit while pending overwrites the pending snapshot (last wins).
- ENABLE with pending set: pending moves to staging, pending_o clears, and the FSM goes to DRAIN (enables were just re-asserted) instead of IDLE. done_o still pulses.
- Commit in IDLE on the same cycle the FSM enters IDLE behaves as an ordinary IDLE commit.
- Configuration outputs change only in SWITCH. Enables change only on commit acceptance (to 0) or in ENABLE.

## Timing
- Reset (rst_i high at an edge): every output is 0, FSM goes to IDLE, and the staging, pending and counter registers clear. Reset mid-sequence aborts it with no done_o.
- Commit sampled at edge 0 with enables active and drain=N, settle=S:
  - busy_o=1 and enables=0 from cycle 1.
  - DRAIN covers cycles 1..N.
  - SWITCH is cycle N+1; new configuration is visible from cycle N+2.
  - SETTLE covers N+2..N+1+S.
  - Enables and done_o are high at cycle N+S+2.
  - busy_o=0 from N+S+3.
- All enables off at commit: SWITCH at cycle 1, done at cycle S+2.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: hold rst_i 3 cycles with random inputs -> all outputs 0, busy_o=0, no done_o.
- Cold start: all enables off, commit master_en=1, div_0=8, drain=5, settle=2 -> div_0_o=8 at cycle 2, master_en_o=1 and done_o at cycle 4, busy_o low at cycle 5.
- Live source switch: master running, commit sel_master_ext=1, drain=10, settle=3 -> master_en_o low cycles 1..14, sel_master_ext_o changes at cycle 12, master_en_o high at cycle 15.
- Queued commits: commit A, then B and C during DRAIN -> pending_o=1, A completes with done_o, C is applied with a second done_o, B never appears on the outputs.
- Boundary counts: drain=0, settle=0 with enables on -> DRAIN lasts 1 cycle, SETTLE is skipped, done at cycle 3.
- Reset mid-SETTLE: assert rst_i -> outputs 0 next cycle, no done_o, and a following commit runs a full normal sequence.
